// File: rtl/sort_pkg.sv
// Shared definitions for the one-cycle sorter and its consumers: default sizes,
// the serializer state encoding and a helper to pull one word out of a packed result.
package sort_pkg;

  localparam int SORT_BITWIDTH = 8;
  localparam int SORT_NWORDS   = 8;
  localparam int SORT_PW       = SORT_BITWIDTH * SORT_NWORDS + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Word j (0 = smallest) sits just below the valid flag for j=0, lowest for j=NWORDS-1.
  function automatic logic [SORT_BITWIDTH-1:0] word_at(input logic [SORT_PW-1:0] packed_in,
                                                       input int j);
    logic [SORT_PW-1:0] w_shifted;
    w_shifted = packed_in >> (SORT_BITWIDTH * (SORT_NWORDS - 1 - j));
    return w_shifted[SORT_BITWIDTH-1:0];
  endfunction

endpackage

// File: rtl/sort_result_serializer.sv
// Captures a sorter result on a fresh 0->1 of its valid flag and replays the
// words one per beat on a valid/ready stream, ascending or descending.
module sort_result_serializer
  import sort_pkg::*;
#(
  parameter  int BITWIDTH = SORT_BITWIDTH,
  parameter  int NWORDS   = SORT_NWORDS,
  localparam int PW       = BITWIDTH * NWORDS + 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [PW-1:0]       sort_in,
  input  logic                descending,
  output logic [BITWIDTH-1:0] dout,
  output logic                dout_valid,
  output logic                dout_last,
  input  logic                dout_ready,
  output logic                busy,
  output logic                overrun,
  input  logic                clr_overrun
);

  localparam int            IW       = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_flag_q;
  logic                r_desc;
  logic [IW-1:0]       r_idx;
  logic [BITWIDTH-1:0] r_buf [NWORDS];
  logic [BITWIDTH-1:0] r_dout;
  logic                r_dout_valid;
  logic                r_dout_last;
  logic                r_overrun;

  logic [BITWIDTH-1:0] w_words [NWORDS];
  logic [BITWIDTH-1:0] w_first;
  logic [IW-1:0]       w_idx_inc;
  logic [IW-1:0]       w_rd_idx;
  logic                w_capture;
  logic                w_hs;
  logic                w_last_hs;
  logic                w_load;
  logic                w_drop;

  for (genvar g = 0; g < NWORDS; g++) begin : g_unpack
    assign w_words[g] = sort_in[BITWIDTH*(NWORDS-g)-1 -: BITWIDTH];
  end

  assign w_capture = sort_in[PW-1] && !r_flag_q;
  assign w_first   = descending ? w_words[NWORDS-1] : w_words[0];
  assign w_idx_inc = r_idx + 1'b1;
  assign w_rd_idx  = r_desc ? (LAST_IDX - w_idx_inc) : w_idx_inc;

  // A capture on the final handshake restarts the stream instead of being dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_hs        = r_dout_valid && dout_ready;
    w_last_hs   = w_hs && r_dout_last;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_capture) begin
          w_load      = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_capture && w_last_hs) begin
          w_load = 1'b1;
        end else if (w_capture) begin
          w_drop = 1'b1;
        end else if (w_last_hs) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the word buffer is reset like any other register so that a reset
  // mid-stream leaves no stale data observable; it is only NWORDS entries.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_flag_q     <= 1'b1;
      r_desc       <= 1'b0;
      r_idx        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
      for (int j = 0; j < NWORDS; j++) r_buf[j] <= '0;
    end else begin
      r_flag_q <= sort_in[PW-1];
      if (w_load) begin
        r_buf        <= w_words;
        r_desc       <= descending;
        r_idx        <= '0;
        r_dout       <= w_first;
        r_dout_valid <= 1'b1;
        r_dout_last  <= (NWORDS == 1);
      end else if (w_last_hs) begin
        r_idx        <= '0;
        r_dout_valid <= 1'b0;
        r_dout_last  <= 1'b0;
      end else if (w_hs) begin
        r_idx       <= w_idx_inc;
        r_dout      <= r_buf[w_rd_idx];
        r_dout_last <= (w_idx_inc == LAST_IDX);
      end
    end
  end

  // Set wins over a simultaneous clear so no dropped result goes unreported.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign dout_last  = r_dout_last;
  assign busy       = (r_state == SEND);
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_sort_result_serializer.sv
// Directed bench for sort_result_serializer: expected beats are queued when a
// result is presented and compared as the stream hands them off.
module tb_sort_result_serializer;
  import sort_pkg::*;

  localparam int BW = SORT_BITWIDTH;
  localparam int NW = SORT_NWORDS;
  localparam int PW = SORT_PW;

  typedef struct packed {
    logic [BW-1:0] word;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic [PW-1:0] sort_in;
  logic          descending;
  logic [BW-1:0] dout;
  logic          dout_valid;
  logic          dout_last;
  logic          dout_ready;
  logic          busy;
  logic          overrun;
  logic          clr_overrun;

  sort_result_serializer dut (
    .clk         (clk),
    .resetn      (resetn),
    .sort_in     (sort_in),
    .descending  (descending),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_last   (dout_last),
    .dout_ready  (dout_ready),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            hs_count;
  int            n_last;
  int            cycles;
  exp_t          sb[$];
  logic          stall_prev;
  logic [BW-1:0] prev_dout;
  logic          prev_last;
  logic [BW-1:0] words [NW];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One stream cycle: pick ready, compare any beat that will hand off at the next edge.
  task automatic drive_cycle(input logic rdy);
    exp_t e;
    dout_ready = rdy;
    if (stall_prev) begin
      check("stall_valid", 32'(dout_valid), 32'(1));
      check("stall_dout", 32'(dout), 32'(prev_dout));
      check("stall_last", 32'(dout_last), 32'(prev_last));
    end
    if (dout_valid && rdy) begin
      if (sb.size() == 0) begin
        check("spurious_beat", 32'(dout_valid), 32'(0));
      end else begin
        e = sb.pop_front();
        check($sformatf("beat%0d_word", hs_count), 32'(dout), 32'(e.word));
        check($sformatf("beat%0d_last", hs_count), 32'(dout_last), 32'(e.last));
        hs_count++;
        if (dout_last) n_last++;
      end
    end
    stall_prev = dout_valid && !rdy;
    prev_dout  = dout;
    prev_last  = dout_last;
    tick();
  endtask

  // Present a result with a fresh flag rise and queue the beats it should produce.
  task automatic send_result(input logic desc);
    logic [BW*NW-1:0] data;
    exp_t             e;
    data = '0;
    for (int j = 0; j < NW; j++) data = {data[BW*NW-BW-1:0], words[j]};
    descending = desc;
    sort_in    = {1'b0, data};
    tick();
    sort_in[PW-1] = 1'b1;
    for (int i = 0; i < NW; i++) begin
      e.word = desc ? words[NW-1-i] : words[i];
      e.last = (i == NW - 1);
      sb.push_back(e);
    end
    hs_count   = 0;
    n_last     = 0;
    stall_prev = 1'b0;
    tick();
    check("capture_latency_valid", 32'(dout_valid), 32'(1));
    check("capture_busy", 32'(busy), 32'(1));
  endtask

  task automatic drain(input int budget);
    cycles = 0;
    while (sb.size() > 0 && cycles < budget) begin
      drive_cycle(1'b1);
      cycles++;
    end
    check("drain_timeout", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    logic ready_pat [11];
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    words = '{8'h00, 8'h01, 8'h10, 8'h7E, 8'h7F, 8'h80, 8'hFE, 8'hFF};

    // 1: reset with the flag already high -> nothing captured
    resetn      = 1'b0;
    sort_in     = {1'b1, {(PW-1){1'b1}}};
    descending  = 1'b0;
    dout_ready  = 1'b1;
    clr_overrun = 1'b0;
    stall_prev  = 1'b0;
    tick();
    tick();
    check("rst_dout", 32'(dout), 32'(0));
    check("rst_last", 32'(dout_last), 32'(0));
    resetn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("idle_valid_c%0d", c), 32'(dout_valid), 32'(0));
      check($sformatf("idle_busy_c%0d", c), 32'(busy), 32'(0));
      check($sformatf("idle_ovr_c%0d", c), 32'(overrun), 32'(0));
      tick();
    end

    // 2: ascending, always ready -> 8 back-to-back beats
    send_result(1'b0);
    drain(40);
    check("asc_cycles", 32'(cycles), 32'(NW));
    check("asc_n_last", 32'(n_last), 32'(1));
    check("asc_busy_after", 32'(busy), 32'(0));
    check("asc_valid_after", 32'(dout_valid), 32'(0));

    // 3: same words with a stalling ready pattern
    send_result(1'b0);
    for (int i = 0; i < 11; i++) drive_cycle(ready_pat[i]);
    drain(40);
    check("bp_n_last", 32'(n_last), 32'(1));
    check("bp_busy_after", 32'(busy), 32'(0));

    // 4: descending latched at capture; later toggles are ignored
    send_result(1'b1);
    cycles = 0;
    while (sb.size() > 0 && cycles < 40) begin
      if (hs_count == 3) descending = 1'b0;
      drive_cycle(1'b1);
      cycles++;
    end
    check("desc_drain", 32'(sb.size()), 32'(0));
    check("desc_n_last", 32'(n_last), 32'(1));

    // 5: a new result mid-stream is dropped and flagged
    send_result(1'b0);
    cycles = 0;
    while (sb.size() > 0 && cycles < 40) begin
      if (hs_count == 3) sort_in[PW-1] = 1'b0;
      if (hs_count == 5) sort_in[PW-1] = 1'b1;
      drive_cycle(1'b1);
      cycles++;
    end
    check("ovr_drain", 32'(sb.size()), 32'(0));
    check("ovr_cycles", 32'(cycles), 32'(NW));
    check("ovr_set", 32'(overrun), 32'(1));
    for (int c = 0; c < 3; c++) drive_cycle(1'b1);
    check("ovr_no_replay", 32'(dout_valid), 32'(0));
    check("ovr_sticky", 32'(overrun), 32'(1));
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'(0));

    // 6: reset mid-stream discards the stream; a fresh rise restarts from word 0
    send_result(1'b0);
    cycles = 0;
    while (hs_count < 4 && cycles < 40) begin
      drive_cycle(1'b1);
      cycles++;
    end
    check("pre_reset_beats", 32'(hs_count), 32'(4));
    resetn = 1'b0;
    #1;
    check("async_rst_valid", 32'(dout_valid), 32'(0));
    check("async_rst_busy", 32'(busy), 32'(0));
    check("async_rst_last", 32'(dout_last), 32'(0));
    sb.delete();
    stall_prev = 1'b0;
    tick();
    resetn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("post_rst_valid_c%0d", c), 32'(dout_valid), 32'(0));
      tick();
    end
    send_result(1'b0);
    drain(40);
    check("fresh_cycles", 32'(cycles), 32'(NW));
    check("fresh_n_last", 32'(n_last), 32'(1));
    check("fresh_busy_after", 32'(busy), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
